// File: rtl/ftof_sched.sv
// ftof_sched: shares one fixed-latency float-to-float converter among NREQ
// requesters. A rotating-priority arbiter grants one request from IDLE, the FSM
// holds the operands steady for LAT cycles, captures the result and flags, then
// returns them to the owning requester with a valid/ready handshake.
// Optional feature: define FTOF_SCHED_PERF_EN to add the perf_ops / perf_stall
// counter outputs; without it those ports and counters do not exist.
module ftof_sched #(
    parameter int NREQ  = 2,
    parameter int IN_W  = 32,
    parameter int OUT_W = 64,
    parameter int LAT   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*IN_W-1:0] req_a,
    input  logic [NREQ*3-1:0]    req_rm,
    input  logic                 tininess,
    output logic [IN_W-1:0]      cvt_a,
    output logic [2:0]           cvt_rm,
    output logic                 cvt_control,
    input  logic [OUT_W-1:0]     cvt_out,
    input  logic [4:0]           cvt_flags,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [OUT_W-1:0]     rsp_data,
    output logic [4:0]           rsp_flags,
    output logic                 busy
`ifdef FTOF_SCHED_PERF_EN
    ,
    output logic [31:0]          perf_ops,
    output logic [31:0]          perf_stall
`endif
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);
    localparam logic [NREQ-1:0]  ONE      = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, BUSY, RESP} stateT;

    stateT             state;
    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  owner;
    logic [CNT_W-1:0]  cnt;
    logic [IN_W-1:0]   opA;
    logic [2:0]        opRm;
    logic [OUT_W-1:0]  result;
    logic [4:0]        flags;
    logic [NREQ-1:0]   rspValidR;
    logic              busyR;

    logic              grantHit;
    logic [PTR_W-1:0]  grantIdx;
    logic [PTR_W-1:0]  scanIdx;
    logic              ownerReady;

    // Rotating-priority scan starting at rrPtr; first valid requester wins.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = '0;
        scanIdx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            scanIdx = PTR_W'((int'(rrPtr) + k) % NREQ);
            if (!grantHit && req_valid[scanIdx]) begin
                grantHit = 1'b1;
                grantIdx = scanIdx;
            end
        end
    end

    // Grants only exist in IDLE, so the accept decision never sees an op in flight.
    assign req_ready   = (state == IDLE && !reset && grantHit) ? (ONE << grantIdx) : '0;
    assign ownerReady  = rsp_ready[owner];

    assign cvt_a       = opA;
    assign cvt_rm      = opRm;
    assign cvt_control = tininess;
    assign rsp_valid   = rspValidR;
    assign rsp_data    = result;
    assign rsp_flags   = flags;
    assign busy        = busyR;

    // Scheduler FSM: accept, hold operands for LAT cycles, capture, respond.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rrPtr     <= '0;
            owner     <= '0;
            cnt       <= '0;
            opA       <= '0;
            opRm      <= '0;
            result    <= '0;
            flags     <= '0;
            rspValidR <= '0;
            busyR     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantHit) begin
                        opA   <= req_a[int'(grantIdx)*IN_W +: IN_W];
                        opRm  <= req_rm[int'(grantIdx)*3 +: 3];
                        owner <= grantIdx;
                        cnt   <= '0;
                        busyR <= 1'b1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_LAST) begin
                        result    <= cvt_out;
                        flags     <= cvt_flags;
                        cnt       <= '0;
                        rspValidR <= ONE << owner;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (ownerReady) begin
                        rrPtr     <= (int'(owner) == NREQ - 1) ? '0 : owner + PTR_W'(1);
                        rspValidR <= '0;
                        busyR     <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rspValidR <= '0;
                    busyR     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FTOF_SCHED_PERF_EN
    logic [31:0] perfOps;
    logic [31:0] perfStall;

    // Completed-op and response-backpressure counters; both wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            perfOps   <= '0;
            perfStall <= '0;
        end else if (state == RESP) begin
            if (ownerReady) begin
                perfOps <= perfOps + 32'd1;
            end else begin
                perfStall <= perfStall + 32'd1;
            end
        end
    end

    assign perf_ops   = perfOps;
    assign perf_stall = perfStall;
`endif

endmodule
